// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO and back-to-back frames.
// Define PARITY_EN to add the parity_odd input and a parity bit per frame.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trmt,
  input  logic [DATA_W-1:0]             tx_data,
`ifdef PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          rdy,
  output logic                          TX,
  output logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(BAUD_DIV);
  localparam int BW  = $clog2(DATA_W + 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_PARITY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              r_ovf;
  logic [BCW-1:0]    r_baud;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_tx;
  logic              r_done;
  state_t            r_state;

  logic              w_full;
  logic              w_push;
  logic              w_tc;
  logic              w_last_stop;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic              w_par;

  assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_push      = trmt & ~w_full;
  assign w_tc        = (r_baud == BCW'(BAUD_DIV - 1));
  assign w_last_stop = (r_state == S_STOP) && w_tc
                     && (r_bit == BW'(STOP_BITS - 1));
  assign w_pop       = (r_cnt != '0)
                     && ((r_state == S_IDLE) || w_last_stop);
  assign w_head      = r_mem[r_rptr];
`ifdef PARITY_EN
  assign w_par       = (^w_head) ^ parity_odd;
`else
  assign w_par       = 1'b0;
`endif

  assign rdy      = ~w_full;
  assign TX       = r_tx;
  assign tx_done  = r_done;
  assign busy     = (r_state != S_IDLE);
  assign fifo_cnt = r_cnt;
  assign ovf      = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (trmt && w_full) r_ovf <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      if (r_state != S_IDLE)
        r_baud <= w_tc ? '0 : r_baud + BCW'(1);
      if (w_pop) begin
        // Pop and frame load share one edge so the start bit is gapless
        r_state <= S_START;
        r_shift <= w_head;
        r_par   <= w_par;
        r_baud  <= '0;
        r_tx    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_START: if (w_tc) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
          S_DATA: if (w_tc) begin
            if (r_bit == BW'(DATA_W - 1)) begin
              r_bit <= '0;
`ifdef PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + BW'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
`ifdef PARITY_EN
          S_PARITY: if (w_tc) begin
            r_state <= S_STOP;
            r_bit   <= '0;
            r_tx    <= 1'b1;
          end
`endif
          S_STOP: if (w_tc) begin
            if (r_bit == BW'(STOP_BITS - 1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_push) r_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
// Two instances: 8N1 with BAUD_DIV=16, and 5 data bits with 2 stop bits.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = '0;
  logic       parity_odd = 1'b0;
  logic       rdy, TX, tx_done, busy, ovf;
  logic [2:0] fifo_cnt;

  logic       trmt2 = 1'b0;
  logic [4:0] tx_data2 = '0;
  logic       rdy2, TX2, tx_done2, busy2, ovf2;
  logic [2:0] fifo_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W(8), .BAUD_DIV(16), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
`ifdef PARITY_EN
    .parity_odd(parity_odd),
`endif
    .rdy(rdy), .TX(TX), .tx_done(tx_done), .busy(busy),
    .fifo_cnt(fifo_cnt), .ovf(ovf)
  );

  uart_tx_fifo #(
    .DATA_W(5), .BAUD_DIV(8), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .trmt(trmt2), .tx_data(tx_data2),
`ifdef PARITY_EN
    .parity_odd(parity_odd),
`endif
    .rdy(rdy2), .TX(TX2), .tx_done(tx_done2), .busy(busy2),
    .fifo_cnt(fifo_cnt2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({TX, tx_done, busy, fifo_cnt, ovf, rdy} !== 8'b1_0_0_000_0_1) begin
      errors++;
      $display("FAIL reset TX/done/busy/cnt/ovf/rdy got %b want 10000001",
               {TX, tx_done, busy, fifo_cnt, ovf, rdy});
    end
    checks++;
    if (TX2 !== 1'b1 || busy2 !== 1'b0 || fifo_cnt2 !== 3'd0) begin
      errors++;
      $display("FAIL reset2 TX2=%b busy2=%b cnt2=%0d want 1 0 0",
               TX2, busy2, fifo_cnt2);
    end
  endtask

  task automatic test_single();
    logic [9:0] f;
    f = 10'b1_10100101_0;
    tx_data = 8'hA5;
    trmt = 1'b1;
    tick();
    trmt = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd1 || TX !== 1'b1) begin
      errors++;
      $display("FAIL single_c1 cnt=%0d TX=%b want 1 1", fifo_cnt, TX);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_c2 busy=%b cnt=%0d want 1 0", busy, fifo_cnt);
    end
    for (int c = 0; c < 160; c++) begin
      checks++;
      if (TX !== f[c/16]) begin
        errors++;
        $display("FAIL single_bit c=%0d TX=%b want %b", c, TX, f[c/16]);
      end
      if (c == 159) begin
        checks++;
        if (tx_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL single_last done=%b busy=%b want 0 1",
                   tx_done, busy);
        end
      end
      tick();
    end
    checks++;
    if (tx_done !== 1'b1 || busy !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL single_end done=%b busy=%b TX=%b want 1 0 1",
               tx_done, busy, TX);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    logic [9:0] f;
    logic [2:0] mx;
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tx_data = d[i];
      trmt = 1'b1;
      tick();
      if (i == 0) begin
        checks++;
        if (tx_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_clear done=%b want 0", tx_done);
        end
      end
    end
    trmt = 1'b0;
    mx = fifo_cnt;
    for (int c = 1; c < 480; c++) begin
      f = {1'b1, d[c/160], 1'b0};
      checks++;
      if (TX !== f[(c%160)/16]) begin
        errors++;
        $display("FAIL b2b_bit c=%0d TX=%b want %b", c, TX, f[(c%160)/16]);
      end
      if (c == 159 || c == 319) begin
        checks++;
        if (tx_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap c=%0d done=%b busy=%b want 0 1",
                   c, tx_done, busy);
        end
      end
      if (fifo_cnt > mx) mx = fifo_cnt;
      tick();
    end
    checks++;
    if (mx !== 3'd2) begin
      errors++;
      $display("FAIL b2b_peak cnt=%0d want 2", mx);
    end
    checks++;
    if (tx_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end done=%b busy=%b want 1 0", tx_done, busy);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w [6];
    logic [9:0] f;
    int done_c;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      if (i == 4 || i == 5) begin
        checks++;
        if (rdy !== (i == 4)) begin
          errors++;
          $display("FAIL ovf_rdy i=%0d rdy=%b want %b", i, rdy, i == 4);
        end
      end
      tx_data = w[i];
      trmt = 1'b1;
      tick();
    end
    trmt = 1'b0;
    checks++;
    if (ovf !== 1'b1 || fifo_cnt !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set ovf=%b cnt=%0d want 1 4", ovf, fifo_cnt);
    end
    done_c = -1;
    for (int c = 4; c < 1200; c++) begin
      if (tx_done === 1'b1) begin
        done_c = c;
        break;
      end
      if ((c % 16) == 8 && c < 800) begin
        f = {1'b1, w[c/160], 1'b0};
        checks++;
        if (TX !== f[(c%160)/16]) begin
          errors++;
          $display("FAIL ovf_bit c=%0d TX=%b want %b",
                   c, TX, f[(c%160)/16]);
        end
      end
      tick();
    end
    checks++;
    if (done_c != 800) begin
      errors++;
      $display("FAIL ovf_frames done_at=%0d want 800", done_c);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky ovf=%b want 1", ovf);
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] w [3];
    int bad;
    w[0] = 8'h3C; w[1] = 8'h5A; w[2] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      tx_data = w[i];
      trmt = 1'b1;
      tick();
    end
    trmt = 1'b0;
    for (int i = 0; i < 55; i++) tick();
    checks++;
    if (fifo_cnt !== 3'd2 || busy !== 1'b1 || TX !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre cnt=%0d busy=%b TX=%b want 2 1 1",
               fifo_cnt, busy, TX);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({TX, fifo_cnt, busy, ovf, rdy} !== 7'b1_000_0_0_1) begin
      errors++;
      $display("FAIL rstmid_post TX/cnt/busy/ovf/rdy got %b want 1000001",
               {TX, fifo_cnt, busy, ovf, rdy});
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet active_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_stop2();
    logic [4:0] d [2];
    logic [7:0] f [2];
    d[0] = 5'h1F; f[0] = 8'b11_11111_0;
    d[1] = 5'h05; f[1] = 8'b11_00101_0;
    for (int v = 0; v < 2; v++) begin
      tx_data2 = d[v];
      trmt2 = 1'b1;
      tick();
      trmt2 = 1'b0;
      tick();
      for (int c = 0; c < 64; c++) begin
        checks++;
        if (TX2 !== f[v][c/8]) begin
          errors++;
          $display("FAIL stop2_bit v=%0d c=%0d TX=%b want %b",
                   v, c, TX2, f[v][c/8]);
        end
        if (c == 63) begin
          checks++;
          if (tx_done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL stop2_last v=%0d done=%b busy=%b want 0 1",
                     v, tx_done2, busy2);
          end
        end
        tick();
      end
      checks++;
      if (tx_done2 !== 1'b1 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL stop2_end v=%0d done=%b busy=%b want 1 0",
                 v, tx_done2, busy2);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [10:0] f [2];
    f[0] = 11'b1_1_00000111_0;
    f[1] = 11'b1_0_00000111_0;
    for (int v = 0; v < 2; v++) begin
      parity_odd = (v == 1);
      tx_data = 8'h07;
      trmt = 1'b1;
      tick();
      trmt = 1'b0;
      tick();
      for (int c = 0; c < 176; c++) begin
        checks++;
        if (TX !== f[v][c/16]) begin
          errors++;
          $display("FAIL parity_bit v=%0d c=%0d TX=%b want %b",
                   v, c, TX, f[v][c/16]);
        end
        tick();
      end
      checks++;
      if (tx_done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_end v=%0d done=%b busy=%b want 1 0",
                 v, tx_done, busy);
      end
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
`ifdef PARITY_EN
    test_parity();
`else
    test_single();
    test_back_to_back();
    test_overflow();
    test_rst_mid();
    test_stop2();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
